// File: rtl/ising_run_ctrl.sv
// Run controller for a coupled-oscillator Ising array: hold in reset, anneal, sample, report.
// Define RUN_CTRL_MAJORITY_EN for 2-of-3 majority spin capture over a 5-cycle SAMPLE window.
module ising_run_ctrl #(
  parameter int N     = 8,
  parameter int RUN_W = 32
) (
  input  logic             clk,
  input  logic             axi_rst,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      rst_cycles,
  input  logic [RUN_W-1:0] run_cycles,
  input  logic [N-1:0]     phase_in,
  input  logic             ref_phase,
  output logic             ising_rstn,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     spins
);

`ifdef RUN_CTRL_MAJORITY_EN
  localparam logic [2:0] SAMP_LAST = 3'd4;
`else
  localparam logic [2:0] SAMP_LAST = 3'd2;
`endif

  typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_SAMPLE, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [15:0]      rst_cnt_q, rst_cnt_d;
  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [2:0]       samp_cnt_q, samp_cnt_d;
  logic [N-1:0]     phase_s1_q, phase_s2_q;
  logic             ref_s1_q, ref_s2_q;
  logic [N-1:0]     spins_q, spins_d;
  logic             ising_rstn_q, ising_rstn_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [N-1:0]     match;
  logic [N-1:0]     captured;
  logic             capture;

  assign match = ~(phase_s2_q ^ {N{ref_s2_q}});

`ifdef RUN_CTRL_MAJORITY_EN
  logic [N-1:0] vote_a_q, vote_b_q;

  // First two votes come from SAMPLE cycles 3 and 4; the live match supplies the third on cycle 5.
  always_ff @(posedge clk) begin
    if (axi_rst) begin
      vote_a_q <= '0;
      vote_b_q <= '0;
    end else if (state_q == S_SAMPLE) begin
      if (samp_cnt_q == 3'd2) vote_a_q <= match;
      if (samp_cnt_q == 3'd1) vote_b_q <= match;
    end
  end

  assign captured = (vote_a_q & vote_b_q) | (vote_a_q & match) | (vote_b_q & match);
`else
  assign captured = match;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (axi_rst) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= '0;
      run_len_q    <= '0;
      run_cnt_q    <= '0;
      samp_cnt_q   <= '0;
      phase_s1_q   <= '0;
      phase_s2_q   <= '0;
      ref_s1_q     <= 1'b0;
      ref_s2_q     <= 1'b0;
      spins_q      <= '0;
      ising_rstn_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      run_len_q    <= run_len_d;
      run_cnt_q    <= run_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      phase_s1_q   <= phase_in;
      phase_s2_q   <= phase_s1_q;
      ref_s1_q     <= ref_phase;
      ref_s2_q     <= ref_s1_q;
      spins_q      <= spins_d;
      ising_rstn_q <= ising_rstn_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    run_len_d  = run_len_q;
    run_cnt_d  = run_cnt_q;
    samp_cnt_d = samp_cnt_q;
    capture    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d   = S_RESET;
          rst_cnt_d = (rst_cycles == 16'd0) ? 16'd0 : rst_cycles - 16'd1;
          run_len_d = run_cycles;
        end
      end
      S_RESET: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (rst_cnt_q != 16'd0) begin
          rst_cnt_d = rst_cnt_q - 16'd1;
        end else if (run_len_q == '0) begin
          state_d    = S_SAMPLE;
          samp_cnt_d = SAMP_LAST;
        end else begin
          state_d   = S_RUN;
          run_cnt_d = run_len_q - RUN_W'(1);
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (run_cnt_q != '0) begin
          run_cnt_d = run_cnt_q - RUN_W'(1);
        end else begin
          state_d    = S_SAMPLE;
          samp_cnt_d = SAMP_LAST;
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (samp_cnt_q != 3'd0) begin
          samp_cnt_d = samp_cnt_q - 3'd1;
        end else begin
          state_d = S_DONE;
          capture = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    spins_d = capture ? captured : spins_q;
  end

  // Outputs decode the upcoming state so the registered copies line up with the state register.
  always_comb begin
    ising_rstn_d = (state_d == S_RUN) || (state_d == S_SAMPLE);
    busy_d       = (state_d == S_RESET) || (state_d == S_RUN) || (state_d == S_SAMPLE);
    done_d       = (state_d == S_DONE);
  end

  assign ising_rstn = ising_rstn_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign spins      = spins_q;

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Randomized self-checking bench for ising_run_ctrl against a per-run timeline model.
// Compile with RUN_CTRL_MAJORITY_EN defined to exercise the majority-capture build.
module tb_ising_run_ctrl;
  localparam int N     = 8;
  localparam int RUN_W = 8;
`ifdef RUN_CTRL_MAJORITY_EN
  localparam int SAMP = 5;
`else
  localparam int SAMP = 3;
`endif

  logic             clk = 1'b0;
  logic             axi_rst;
  logic             start;
  logic             abort;
  logic [15:0]      rst_cycles;
  logic [RUN_W-1:0] run_cycles;
  logic [N-1:0]     phase_in;
  logic             ref_phase;
  logic             ising_rstn;
  logic             busy;
  logic             done;
  logic [N-1:0]     spins;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [N-1:0] spins_exp;

  ising_run_ctrl #(.N(N), .RUN_W(RUN_W)) dut (
    .clk        (clk),
    .axi_rst    (axi_rst),
    .start      (start),
    .abort      (abort),
    .rst_cycles (rst_cycles),
    .run_cycles (run_cycles),
    .phase_in   (phase_in),
    .ref_phase  (ref_phase),
    .ising_rstn (ising_rstn),
    .busy       (busy),
    .done       (done),
    .spins      (spins)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance into the next cycle; outputs are checked and inputs driven 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run: start is sampled at the end of cycle 0. Timeline from plain arithmetic:
  // RESET 1..R, RUN R+1..R+L, SAMPLE R+L+1..R+L+SAMP, DONE at R+L+SAMP+1, then IDLE.
  task automatic run_txn(input int rst, input int run, input logic [N-1:0] ph, input logic rf,
                         input int abort_at, input bit noise, input bit do_glitch);
    int r, last, d, gpos;
    r    = (rst == 0) ? 1 : rst;
    last = r + run + SAMP;
    d    = last + 1;
`ifdef RUN_CTRL_MAJORITY_EN
    gpos = d - 5 + int'($urandom_range(0, 2));
`else
    gpos = ($urandom_range(0, 1) == 0) ? d - 4 : d - 2;
`endif
    rst_cycles = rst[15:0];
    run_cycles = run[RUN_W-1:0];
    phase_in   = ~ph;
    ref_phase  = rf;
    start      = 1'b1;
    tick();
    start    = 1'b0;
    phase_in = ph;
    for (int j = 1; j <= d + 1; j++) begin
      bit         alive;
      logic [2:0] exp_ctl;
      alive      = (abort_at < 0) || (j <= abort_at);
      exp_ctl[2] = alive && (j <= last);
      exp_ctl[1] = alive && (j > r) && (j <= last);
      exp_ctl[0] = alive && (j == d);
      if (alive && (j == d)) spins_exp = ~(ph ^ {N{rf}});
      check("ctl{busy,rstn,done}", 32'({busy, ising_rstn, done}), 32'(exp_ctl));
      check("spins", 32'(spins), 32'(spins_exp));
      abort = (j == abort_at) || (noise && (j == d) && (abort_at < 0));
      start = noise && (((j % 3 == 2) && (j <= last) && alive) || ((j == d) && (abort_at < 0)));
      if (noise) begin
        rst_cycles = 16'($urandom);
        run_cycles = RUN_W'($urandom);
      end
      phase_in = ph;
      if (do_glitch && (j == gpos)) phase_in[0] = ~ph[0];
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    axi_rst    = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    rst_cycles = '0;
    run_cycles = '0;
    phase_in   = '0;
    ref_phase  = 1'b0;
    spins_exp  = '0;
    repeat (3) tick();
    check("reset_ctl", 32'({busy, ising_rstn, done}), 32'd0);
    check("reset_spins", 32'(spins), 32'd0);
    axi_rst = 1'b0;
    tick();

    // Reference timing and polarity cases.
    run_txn(4, 10, 8'hA5, 1'b1, -1, 1'b0, 1'b0);
    run_txn(0, 0, 8'hA5, 1'b0, -1, 1'b0, 1'b0);
    run_txn(4, 10, 8'h3C, 1'b1, 8, 1'b1, 1'b0);
    run_txn(4, 10, 8'h3C, 1'b1, -1, 1'b0, 1'b1);

    // start and abort together in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle_c1", 32'({busy, ising_rstn, done}), 32'd0);
    tick();
    check("start_abort_idle_c2", 32'({busy, ising_rstn, done}), 32'd0);

    // Synchronous reset at cycle 6 of a run abandons it and clears spins.
    rst_cycles = 16'd4;
    run_cycles = RUN_W'(10);
    phase_in   = 8'hF0;
    ref_phase  = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    axi_rst = 1'b1;
    tick();
    axi_rst   = 1'b0;
    spins_exp = '0;
    check("axi_rst_spins", 32'(spins), 32'd0);
    for (int k = 0; k < 15; k++) begin
      check("axi_rst_ctl", 32'({busy, ising_rstn, done}), 32'd0);
      tick();
    end

    // Longest representable run still finishes.
    run_txn(1, (1 << RUN_W) - 1, 8'h81, 1'b0, -1, 1'b0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      int rr, ll, ab, lst;
      rr  = int'($urandom_range(0, 6));
      ll  = int'($urandom_range(0, 12));
      lst = ((rr == 0) ? 1 : rr) + ll + SAMP;
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lst)) : -1;
      run_txn(rr, ll, N'($urandom), 1'($urandom), ab, 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
